// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns execute-stage redirect/hold requests into
// registered redirect pulses, flush windows and a supervised multi-cycle unit handshake.
module pipe_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned MC_TIMEOUT   = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   input  logic        mc_done_i,
   input  logic        bus_hold_i,
   output logic        jump_en_o,
   output logic [31:0] jump_addr_o,
   output logic        flush_o,
   output logic        hold_o,
   output logic        mc_start_o,
   output logic        busy_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FLUSH   = 2'd1,
      MC_BUSY = 2'd2
   } state_t;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
   localparam logic [9:0] TMO_LIMIT  = 10'(MC_TIMEOUT);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  flush_cnt;
   logic [3:0]  flush_cnt_nxt;
   logic [9:0]  tmo_cnt;
   logic [9:0]  tmo_cnt_nxt;
   logic [9:0]  tmo_inc;
   logic        done_ok;
   logic        jump_en_nxt;
   logic [31:0] jump_addr_nxt;
   logic        mc_start_nxt;
   logic        err_nxt;

   function automatic logic [9:0] sat_inc10(input logic [9:0] v, input logic [9:0] lim);
      return (v >= lim) ? lim : v + 10'd1;
   endfunction

   function automatic logic [3:0] sat_dec4(input logic [3:0] v);
      return (v == 4'd0) ? 4'd0 : v - 4'd1;
   endfunction

   // Next-state and next-output decode
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      tmo_cnt_nxt   = tmo_cnt;
      jump_en_nxt   = 1'b0;
      jump_addr_nxt = 32'h0;
      mc_start_nxt  = 1'b0;
      err_nxt       = err_o;
      tmo_inc       = sat_inc10(tmo_cnt, TMO_LIMIT);
      // A done coinciding with the start pulse belongs to a previous operation.
      done_ok       = mc_done_i && !mc_start_o;

      case (state)
         IDLE: begin
            if (jump_en_i) begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = FLUSH_INIT;
               jump_en_nxt   = 1'b1;
               jump_addr_nxt = jump_addr_i;
            end else if (hold_flag_i) begin
               state_nxt    = MC_BUSY;
               tmo_cnt_nxt  = 10'd0;
               mc_start_nxt = 1'b1;
            end
         end
         FLUSH: begin
            if (!bus_hold_i) begin
               flush_cnt_nxt = sat_dec4(flush_cnt);
               if (flush_cnt <= 4'd1) begin
                  state_nxt = IDLE;
               end
            end
         end
         MC_BUSY: begin
            tmo_cnt_nxt = tmo_inc;
            if (done_ok) begin
               state_nxt = IDLE;
            end else if (tmo_inc == TMO_LIMIT) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered state and outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         flush_cnt   <= 4'd0;
         tmo_cnt     <= 10'd0;
         jump_en_o   <= 1'b0;
         jump_addr_o <= 32'h0;
         flush_o     <= 1'b0;
         mc_start_o  <= 1'b0;
         busy_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state       <= state_nxt;
         flush_cnt   <= flush_cnt_nxt;
         tmo_cnt     <= tmo_cnt_nxt;
         jump_en_o   <= jump_en_nxt;
         jump_addr_o <= jump_addr_nxt;
         flush_o     <= (state_nxt == FLUSH);
         mc_start_o  <= mc_start_nxt;
         busy_o      <= (state_nxt != IDLE);
         err_o       <= err_nxt;
      end
   end

   // The bus stall must reach the front-end registers in the same cycle.
   assign hold_o = (state == MC_BUSY) || bus_hold_i;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by randomized
// traffic, all compared against a cycle-count reference model.
module tb_pipe_ctrl;

   localparam int FLUSH_CYCLES = 3;
   localparam int MC_TIMEOUT   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        hold_flag_i;
   logic        mc_done_i;
   logic        bus_hold_i;
   logic        jump_en_o;
   logic [31:0] jump_addr_o;
   logic        flush_o;
   logic        hold_o;
   logic        mc_start_o;
   logic        busy_o;
   logic        err_o;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: flush cycles remaining, cycles spent in the multi-cycle
   // operation (-1 when none), and whether the redirect was issued last edge.
   int          m_flush_left;
   int          m_mc_age;
   bit          m_fresh;
   bit          m_err;
   logic [31:0] m_addr;

   pipe_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MC_TIMEOUT(MC_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
      .hold_flag_i(hold_flag_i), .mc_done_i(mc_done_i), .bus_hold_i(bus_hold_i),
      .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o), .flush_o(flush_o),
      .hold_o(hold_o), .mc_start_o(mc_start_o), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_flush_left = 0;
      m_mc_age     = -1;
      m_fresh      = 1'b0;
      m_err        = 1'b0;
      m_addr       = 32'h0;
   endtask

   task automatic model_step(input bit j, input logic [31:0] a, input bit h, input bit d, input bit b);
      bit fresh = 1'b0;
      if (m_flush_left > 0) begin
         if (!b) m_flush_left = m_flush_left - 1;
      end else if (m_mc_age >= 0) begin
         if (d && m_mc_age > 0) begin
            m_mc_age = -1;
         end else begin
            m_mc_age = m_mc_age + 1;
            if (m_mc_age >= MC_TIMEOUT) begin
               m_mc_age = -1;
               m_err    = 1'b1;
            end
         end
      end else if (j) begin
         m_flush_left = FLUSH_CYCLES;
         m_addr       = a;
         fresh        = 1'b1;
      end else if (h) begin
         m_mc_age = 0;
      end
      m_fresh = fresh;
   endtask

   task automatic check_regs();
      chk("jump_en",   jump_en_o,   m_fresh);
      chk("jump_addr", jump_addr_o, m_fresh ? m_addr : 32'h0);
      chk("flush",     flush_o,     m_flush_left > 0);
      chk("mc_start",  mc_start_o,  m_mc_age == 0);
      chk("busy",      busy_o,      (m_flush_left > 0) || (m_mc_age >= 0));
      chk("err",       err_o,       m_err);
   endtask

   // Called at a falling edge: drive one cycle of inputs, check, advance.
   task automatic run_cycle(input bit j, input logic [31:0] a, input bit h, input bit d, input bit b);
      jump_en_i   = j;
      jump_addr_i = a;
      hold_flag_i = h;
      mc_done_i   = d;
      bus_hold_i  = b;
      #1;
      chk("hold", hold_o, (m_mc_age >= 0) || b);
      @(posedge clk);
      model_step(j, a, h, d, b);
      @(negedge clk);
      check_regs();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   // Called at a falling edge: reset lands between clock edges.
   task automatic async_reset();
      jump_en_i   = 1'b0;
      jump_addr_i = 32'h0;
      hold_flag_i = 1'b0;
      mc_done_i   = 1'b0;
      bus_hold_i  = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_hold", hold_o, 1'b0);
      check_regs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_regs();
   endtask

   initial begin
      rst         = 1'b1;
      jump_en_i   = 1'b0;
      jump_addr_i = 32'h0;
      hold_flag_i = 1'b0;
      mc_done_i   = 1'b0;
      bus_hold_i  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_regs();
      chk("reset_hold", hold_o, 1'b0);
      rst = 1'b0;

      // Plain redirect, then a redirect whose flush is stretched by a stall
      idle_cycles(2);
      run_cycle(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
      idle_cycles(FLUSH_CYCLES + 1);
      run_cycle(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
      run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      idle_cycles(FLUSH_CYCLES + 1);

      // Jump beats hold; a jump inside the flush window is ignored
      run_cycle(1'b1, 32'hCAFE_0004, 1'b1, 1'b0, 1'b0);
      run_cycle(1'b1, 32'hDEAD_0008, 1'b1, 1'b0, 1'b0);
      idle_cycles(FLUSH_CYCLES + 1);

      // Multi-cycle with a stray done on the start cycle, then a real done
      run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      run_cycle(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
      idle_cycles(4);
      run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      idle_cycles(2);

      // Timeout: sticky error, then reset in the middle of a new operation
      run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle_cycles(MC_TIMEOUT + 3);
      run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle_cycles(3);
      async_reset();
      idle_cycles(2);

      // Randomized traffic with periodic asynchronous resets
      for (int cyc = 0; cyc < 3000; cyc++) begin
         run_cycle($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
         if (cyc % 700 == 350) async_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller sitting between the execute stage and the front-end registers (pc_reg, if_id, id_ex). It converts execute-stage redirect and hold requests into registered redirect pulses, multi-cycle flush windows and hold windows. It also starts and supervises one multi-cycle execution unit, such as a divider, through a start/done handshake with a timeout. All control outputs are registered except `hold_o`, which also passes the external bus stall through combinationally.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `flush_o` stays high after a taken redirect; legal range 1–15.
- `MC_TIMEOUT`, default 64: maximum cycles to wait for `mc_done_i` after `mc_start_o`; legal range 2–1023.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `jump_en_i` in 1: execute stage requests a redirect this cycle.
- `jump_addr_i` in 32: redirect target; valid when `jump_en_i`=1.
- `hold_flag_i` in 1: execute stage requests a multi-cycle operation.
- `mc_done_i` in 1: multi-cycle unit has finished; single-cycle pulse.
- `bus_hold_i` in 1: external memory/bus stall.
- `jump_en_o` out 1: one-cycle redirect pulse to pc_reg.
- `jump_addr_o` out 32: registered redirect target; valid while `jump_en_o`=1, otherwise 0.
- `flush_o` out 1: clears if_id and id_ex (inserts bubbles).
- `hold_o` out 1: freezes pc_reg, if_id and id_ex.
- `mc_start_o` out 1: one-cycle start pulse to the multi-cycle unit.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `err_o` out 1: sticky timeout error; cleared only by `rst`.

## Operation
- States: IDLE, FLUSH, MC_BUSY.
- Reset: state=IDLE, flush counter=0, timeout counter=0. All outputs are 0, and `jump_addr_o`=32'h0.
- IDLE with `jump_en_i`=1 at cycle N:
  - The address is captured.
  - At N+1: `jump_en_o`=1, `jump_addr_o`=captured address, state=FLUSH, counter=FLUSH_CYCLES.
- IDLE with `hold_flag_i`=1 and `jump_en_i`=0 at cycle N:
  - At N+1: `mc_start_o`=1 (one cycle only), state=MC_BUSY, timeout counter=0.
- Simultaneous `jump_en_i` and `hold_flag_i` in IDLE: the jump wins and the hold request is dropped.
- FLUSH:
  - `flush_o`=1 in every FLUSH cycle.
  - The counter decrements by 1 in each cycle where `bus_hold_i`=0 and freezes while `bus_hold_i`=1.
  - When the counter is 1 and decrements, the next state is IDLE.
  - `jump_en_i` and `hold_flag_i` are ignored in FLUSH because they come from flushed instructions.
  - `jump_en_o` is high only in the first FLUSH cycle.
- MC_BUSY:
  - `mc_done_i` is accepted only from the cycle after `mc_start_o` onward; `mc_done_i` in the `mc_start_o` cycle or outside MC_BUSY is ignored.
  - On an accepted `mc_done_i` at cycle M: state=IDLE at M+1.
  - The timeout counter increments every MC_BUSY cycle. When it reaches MC_TIMEOUT without done, `err_o` is set and the state returns to IDLE.
  - `jump_en_i` is ignored in MC_BUSY.
- `hold_o` = (state==MC_BUSY) OR `bus_hold_i`. This is combinational, so `bus_hold_i` is reflected in the same cycle in every state.
- `bus_hold_i` in IDLE does not block acceptance of `jump_en_i` or `hold_flag_i`; the execute stage keeps its request stable under hold, and the controller accepts it once.
- Widths:
  - Flush counter is 4 bits.
  - Timeout counter is 10 bits.
  - Counters do not wrap; they saturate at their terminal condition.
- Reset mid-operation: immediately forces IDLE and zeroes all outputs, including `err_o`. A pending redirect or multi-cycle operation is discarded.

## Timing
- Redirect latency: `jump_en_i` at N gives `jump_en_o` at N+1.
- Flush window: `flush_o` high in cycles N+1 through N+FLUSH_CYCLES when no bus stall occurs; each stalled cycle extends the window by 1.
- Multi-cycle start: `hold_flag_i` at N gives `mc_start_o` and `hold_o` high at N+1.
- Multi-cycle completion: accepted `mc_done_i` at M means `hold_o` (absent `bus_hold_i`) and `busy_o` are low at M+1.
- Timeout: with no done, MC_BUSY lasts exactly MC_TIMEOUT cycles, then `err_o`=1 from the first IDLE cycle onward.
- `busy_o` is registered as the state decode. The earliest new request after returning to IDLE is accepted in the first IDLE cycle.

## Test plan
- Redirect: reset, then `jump_en_i`=1 with `jump_addr_i`=32'h0000_0100 at cycle 5.
  - Required: `jump_en_o`=1 and `jump_addr_o`=32'h100 at cycle 6 only.
  - Required: `flush_o`=1 at cycles 6–7, and state IDLE at cycle 8.
- Flush under stall: same as the redirect case, plus `bus_hold_i`=1 at cycle 6.
  - Required: `flush_o`=1 at cycles 6–8, and `hold_o`=1 at cycle 6.
- Multi-cycle: `hold_flag_i` at cycle 3 and `mc_done_i` at cycle 10.
  - Required: `mc_start_o` at cycle 4 only, and `hold_o`=1 at cycles 4–10.
  - Required: `hold_o`=0 at cycle 11. A stray `mc_done_i` at cycle 4 has no effect.
- Timeout: MC_TIMEOUT=8, `hold_flag_i` at cycle 2, no done.
  - Required: MC_BUSY at cycles 3–10, IDLE with `err_o`=1 at cycle 11, and `err_o` stays 1 until `rst`.
- Priority and ignore: `jump_en_i`+`hold_flag_i` at cycle 2, then `jump_en_i` at cycle 3 during FLUSH.
  - Required: only one `jump_en_o` (cycle 3, with the cycle-2 address) and no `mc_start_o`.
- Async reset: assert `rst` mid-MC_BUSY (not on a clock edge).
  - Required: `hold_o`, `busy_o` and `err_o` go to 0 immediately, and the first post-reset cycle is IDLE.
